filter_blur_nch: RTL and testbench



---
 rtl/filter_blur_nch.sv | 247 ++++++++++++++++++++++++
 tb/tb_filter_blur_nch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_blur_nch.sv
// filter_blur_nch: 3x3 kernel filter (bypass, gauss, cross, horizontal) over CHANNELS packed
// channels with its own 2-line buffer. Define FILTER_BLUR_NCH_ROUND_EN for round-half-up results.
module filter_blur_nch #(
  parameter int LINE_SIZE_MAX = 1024,
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] di_i,
  input  logic                           de_i,
  input  logic                           hs_i,
  input  logic                           vs_i,
  input  logic [1:0]                     mode_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] do_o,
  output logic                           de_o,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           ovf_o
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 4;
  localparam int AW = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
  localparam int CW = $clog2(LINE_SIZE_MAX + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(LINE_SIZE_MAX);

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GAUSS  = 2'd1;
  localparam logic [1:0] MODE_CROSS  = 2'd2;
  localparam logic [1:0] MODE_HORIZ  = 2'd3;

  function automatic logic [2:0] shift_of(input logic [1:0] m);
    shift_of = 3'd0;
    case (m)
      MODE_GAUSS:  shift_of = 3'd4;
      MODE_CROSS:  shift_of = 3'd3;
      MODE_HORIZ:  shift_of = 3'd2;
      MODE_BYPASS: shift_of = 3'd0;
      default:     shift_of = 3'd0;
    endcase
  endfunction

`ifdef FILTER_BLUR_NCH_ROUND_EN
  function automatic logic [SW-1:0] round_of(input logic [1:0] m);
    logic [2:0] sh;
    sh = shift_of(m);
    round_of = (sh == 3'd0) ? '0 : (SW'(1) << (sh - 3'd1));
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Position counters, mode latch and overflow status
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_cnt;
  logic [1:0]    row_cnt;
  logic [1:0]    mode_q;
  logic          de_d;
  logic          vs_d;
  logic          vs_rise;
  logic [CW-1:0] col_eff;
  logic [1:0]    row_eff;
  logic          in_range;
  logic          pix_valid;
  logic          win_valid;

  // A frame start overrides the running counters, so a pixel on that cycle is (0,0).
  assign vs_rise   = vs_i & ~vs_d;
  assign col_eff   = vs_rise ? '0 : col_cnt;
  assign row_eff   = vs_rise ? '0 : row_cnt;
  assign in_range  = (col_eff < COL_MAX);
  assign pix_valid = de_i & in_range;
  assign win_valid = pix_valid && (col_eff >= CW'(2)) && (row_eff == 2'd2);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      mode_q  <= mode_i;
      de_d    <= 1'b0;
      vs_d    <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      de_d <= de_i;
      vs_d <= vs_i;
      if (vs_rise) begin
        mode_q  <= mode_i;
        ovf_o   <= 1'b0;
        row_cnt <= '0;
        col_cnt <= de_i ? CW'(1) : '0;
      end else if (de_i) begin
        if (in_range) col_cnt <= col_cnt + CW'(1);
        else          ovf_o   <= 1'b1;
      end else if (de_d) begin
        col_cnt <= '0;
        if (row_cnt != 2'd2) row_cnt <= row_cnt + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers (read-before-write) and 3x3 window
  // ---------------------------------------------------------------------------
  logic [PW-1:0] lb0 [LINE_SIZE_MAX];
  logic [PW-1:0] lb1 [LINE_SIZE_MAX];
  logic [AW-1:0] addr;
  logic [PW-1:0] mid_rd;
  logic [PW-1:0] top_rd;

  assign addr   = col_eff[AW-1:0];
  assign mid_rd = lb0[addr];
  assign top_rd = lb1[addr];

  // NOTE: the line RAMs have no reset; rows 0 and 1 of each frame refill them before any output.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0[addr] <= di_i;
      lb1[addr] <= mid_rd;
    end
  end

  // Column taps: *1 is one pixel back, *2 two pixels back; the newest column is combinational.
  logic [PW-1:0] top1, top2, mid1, mid2, bot1, bot2;

  always_ff @(posedge clk) begin
    if (rst) begin
      top1 <= '0; top2 <= '0;
      mid1 <= '0; mid2 <= '0;
      bot1 <= '0; bot2 <= '0;
    end else if (pix_valid) begin
      top1 <= top_rd; top2 <= top1;
      mid1 <= mid_rd; mid2 <= mid1;
      bot1 <= di_i;   bot2 <= bot1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic pipeline: stage 0 pair sums .. stage 4 output register
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   s0_ot [CHANNELS];
  logic [DATA_WIDTH:0]   s0_om [CHANNELS];
  logic [DATA_WIDTH:0]   s0_ob [CHANNELS];
  logic [DATA_WIDTH-1:0] s0_ct [CHANNELS];
  logic [DATA_WIDTH-1:0] s0_cm [CHANNELS];
  logic [DATA_WIDTH-1:0] s0_cb [CHANNELS];
  logic [SW-1:0]         s1_t  [CHANNELS];
  logic [SW-1:0]         s1_m  [CHANNELS];
  logic [SW-1:0]         s1_b  [CHANNELS];
  logic [SW-1:0]         s2_tb [CHANNELS];
  logic [SW-1:0]         s2_m  [CHANNELS];
  logic [SW-1:0]         s3_sum[CHANNELS];
  logic [1:0]            m0, m1, m2, m3;
  logic [3:0]            v_pipe, hs_pipe, vs_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        s0_ot[k] <= '0; s0_om[k] <= '0; s0_ob[k] <= '0;
        s0_ct[k] <= '0; s0_cm[k] <= '0; s0_cb[k] <= '0;
        s1_t[k]  <= '0; s1_m[k]  <= '0; s1_b[k]  <= '0;
        s2_tb[k] <= '0; s2_m[k]  <= '0; s3_sum[k] <= '0;
      end
      m0 <= '0; m1 <= '0; m2 <= '0; m3 <= '0;
      v_pipe  <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        s0_ot[k] <= {1'b0, top2[k*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, top_rd[k*DATA_WIDTH +: DATA_WIDTH]};
        s0_om[k] <= {1'b0, mid2[k*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, mid_rd[k*DATA_WIDTH +: DATA_WIDTH]};
        s0_ob[k] <= {1'b0, bot2[k*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, di_i[k*DATA_WIDTH +: DATA_WIDTH]};
        s0_ct[k] <= top1[k*DATA_WIDTH +: DATA_WIDTH];
        s0_cm[k] <= mid1[k*DATA_WIDTH +: DATA_WIDTH];
        s0_cb[k] <= bot1[k*DATA_WIDTH +: DATA_WIDTH];

        // Row weights per kernel; bypass routes the centre tap through with unit weight.
        case (m0)
          MODE_GAUSS: begin
            s1_t[k] <= SW'(s0_ot[k]) + (SW'(s0_ct[k]) << 1);
            s1_m[k] <= (SW'(s0_om[k]) << 1) + (SW'(s0_cm[k]) << 2);
            s1_b[k] <= SW'(s0_ob[k]) + (SW'(s0_cb[k]) << 1);
          end
          MODE_CROSS: begin
            s1_t[k] <= SW'(s0_ct[k]);
            s1_m[k] <= SW'(s0_om[k]) + (SW'(s0_cm[k]) << 2);
            s1_b[k] <= SW'(s0_cb[k]);
          end
          MODE_HORIZ: begin
            s1_t[k] <= '0;
            s1_m[k] <= SW'(s0_om[k]) + (SW'(s0_cm[k]) << 1);
            s1_b[k] <= '0;
          end
          default: begin
            s1_t[k] <= '0;
            s1_m[k] <= SW'(s0_cm[k]);
            s1_b[k] <= '0;
          end
        endcase

        s2_tb[k] <= s1_t[k] + s1_b[k];
        s2_m[k]  <= s1_m[k];
`ifdef FILTER_BLUR_NCH_ROUND_EN
        s3_sum[k] <= s2_tb[k] + s2_m[k] + round_of(m2);
`else
        s3_sum[k] <= s2_tb[k] + s2_m[k];
`endif
      end
      m0 <= mode_q;
      m1 <= m0;
      m2 <= m1;
      m3 <= m2;
      v_pipe  <= {v_pipe[2:0],  win_valid};
      hs_pipe <= {hs_pipe[2:0], hs_i};
      vs_pipe <= {vs_pipe[2:0], vs_i};
    end
  end

  logic [SW-1:0] shv [CHANNELS];
  logic [PW-1:0] res;

  // NOTE: every variable here is assigned on every pass before it is read, so no latch is inferred.
  always_comb begin
    res = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      shv[k] = s3_sum[k] >> shift_of(m3);
      if (|shv[k][SW-1:DATA_WIDTH]) res[k*DATA_WIDTH +: DATA_WIDTH] = '1;
      else                          res[k*DATA_WIDTH +: DATA_WIDTH] = shv[k][DATA_WIDTH-1:0];
    end
  end

  // do_o only moves on valid pixels and otherwise holds the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      if (v_pipe[3]) do_o <= res;
      de_o <= v_pipe[3];
      hs_o <= hs_pipe[3];
      vs_o <= vs_pipe[3];
    end
  end

endmodule

// File: tb/tb_filter_blur_nch.sv
// Scoreboard bench for filter_blur_nch: a reference 3x3 model queues expected pixels and
// arrival cycles as stimulus is driven; a negedge monitor pops and compares each de_o pulse.
module tb_filter_blur_nch;

  localparam int LSM = 16;
  localparam int DW  = 8;
  localparam int CH  = 3;
  localparam int PW  = CH * DW;

  typedef struct {
    logic [PW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] di_i = '0;
  logic          de_i = 1'b0;
  logic          hs_i = 1'b0;
  logic          vs_i = 1'b0;
  logic [1:0]    mode_i = 2'd1;
  logic [PW-1:0] do_o;
  logic          de_o, hs_o, vs_o, ovf_o;

  filter_blur_nch #(.LINE_SIZE_MAX(LSM), .DATA_WIDTH(DW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .mode_i(mode_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            pulses = 0;
  bit            mon_en = 1'b0;
  bit            hist_hs [8192];
  bit            hist_vs [8192];
  exp_t          sb_q [$];
  logic [PW-1:0] obs_q [$];
  logic [PW-1:0] img [0:15][0:31];
  logic [1:0]    frame_mode = 2'd1;
  logic [1:0]    mode_drv = 2'd1;
  logic          ovf_exp = 1'b0;
  exp_t          e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sync pass-through every cycle, scoreboard pop on each de_o pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc >= 5) begin
        total++;
        if (hs_o !== hist_hs[cyc-5] || vs_o !== hist_vs[cyc-5]) begin
          bad++;
          $display("FAIL sync cyc=%0d hs_o=%b vs_o=%b want hs=%b vs=%b",
                   cyc, hs_o, vs_o, hist_hs[cyc-5], hist_vs[cyc-5]);
        end
      end
      if (de_o === 1'b1) begin
        pulses++;
        obs_q.push_back(do_o);
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_de cyc=%0d do_o=%h", cyc, do_o);
        end else begin
          e = sb_q.pop_front();
          if (do_o !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL pixel got=%h@%0d want=%h@%0d", do_o, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  function automatic logic [PW-1:0] make_pix(input int p, input int x, input int y);
    logic [PW-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      case (p)
        0:       v = 100;
        1:       v = (x == 2 && y == 2) ? 255 : 0;
        2:       v = 10 * (c + 1);
        default: v = int'($urandom_range(0, 255));
      endcase
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  // Reference kernel evaluated on the stored image, window bottom-right at (x, y).
  function automatic logic [PW-1:0] kern(input int y, input int x, input logic [1:0] m);
    int wt[9];
    int sh;
    int s;
    logic [PW-1:0] r;
    logic [PW-1:0] px;
    case (m)
      2'd1:    begin wt = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; sh = 4; end
      2'd2:    begin wt = '{0, 1, 0, 1, 4, 1, 0, 1, 0}; sh = 3; end
      2'd3:    begin wt = '{0, 0, 0, 1, 2, 1, 0, 0, 0}; sh = 2; end
      default: begin wt = '{0, 0, 0, 0, 1, 0, 0, 0, 0}; sh = 0; end
    endcase
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          px = img[y-2+i][x-2+j];
          s += wt[i*3+j] * int'(px[c*DW +: DW]);
        end
`ifdef FILTER_BLUR_NCH_ROUND_EN
      if (sh > 0) s += 1 << (sh - 1);
`endif
      s = s >> sh;
      if (s > 255) s = 255;
      r[c*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic drive(input logic r, input logic de, input logic [PW-1:0] d,
                       input logic hs, input logic vs);
    rst = r; de_i = de; di_i = d; hs_i = hs; vs_i = vs; mode_i = mode_drv;
    hist_hs[cyc] = r ? 1'b0 : hs;
    hist_vs[cyc] = r ? 1'b0 : vs;
    if (r) begin
      for (int i = 1; i <= 4; i++)
        if (cyc - i >= 0) begin
          hist_hs[cyc-i] = 1'b0;
          hist_vs[cyc-i] = 1'b0;
        end
      for (int i = sb_q.size() - 1; i >= 0; i--)
        if (sb_q[i].cyc > cyc) sb_q.delete(i);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame_start(input logic [1:0] m);
    mode_drv = m;
    frame_mode = m;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    ovf_exp = 1'b0;
    total++;
    if (ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear_on_vs got=%b want=0", ovf_o);
    end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic send_line(input int y, input int w, input int p);
    logic [PW-1:0] d;
    exp_t x_e;
    for (int x = 0; x < w; x++) begin
      d = make_pix(p, x, y);
      if (x < LSM) img[y][x] = d;
      if (x >= 2 && y >= 2 && x < LSM) begin
        x_e.data = kern(y, x, frame_mode);
        x_e.cyc  = cyc + 5;
        sb_q.push_back(x_e);
      end
      if (x >= LSM) ovf_exp = 1'b1;
      drive(1'b0, 1'b1, d, 1'b0, 1'b0);
      total++;
      if (ovf_o !== ovf_exp) begin
        bad++;
        $display("FAIL ovf y=%0d x=%0d got=%b want=%b", y, x, ovf_o, ovf_exp);
      end
    end
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic end_frame(input string name, input int want_pulses);
    idle(8);
    total++;
    if (pulses != want_pulses) begin
      bad++;
      $display("FAIL %s_pulses got=%0d want=%0d", name, pulses, want_pulses);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got=%0d want=0", name, sb_q.size());
    end
    pulses = 0;
    obs_q.delete();
  endtask

  task automatic test_reset;
    mode_drv = 2'd1;
    frame_mode = 2'd1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (do_o !== '0 || de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0 || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got do=%h de=%b hs=%b vs=%b ovf=%b want all 0",
               do_o, de_o, hs_o, vs_o, ovf_o);
    end
    mon_en = 1'b1;
    idle(2);
  endtask

  task automatic test_flat;
    frame_start(2'd1);
    for (int y = 0; y < 8; y++) send_line(y, 16, 0);
    end_frame("flat", 84);
  endtask

  task automatic test_impulse;
    logic [PW-1:0] want;
    int v[9];
`ifdef FILTER_BLUR_NCH_ROUND_EN
    v = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
`else
    v = '{15, 31, 15, 31, 63, 31, 15, 31, 15};
`endif
    frame_start(2'd1);
    for (int y = 0; y < 5; y++) send_line(y, 5, 1);
    idle(8);
    total++;
    if (obs_q.size() != 9) begin
      bad++;
      $display("FAIL impulse_count got=%0d want=9", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 9; i++) begin
      want = {CH{v[i][DW-1:0]}};
      total++;
      if (obs_q[i] !== want) begin
        bad++;
        $display("FAIL impulse_%0d got=%h want=%h", i, obs_q[i], want);
      end
    end
    end_frame("impulse", 9);
  endtask

  task automatic test_channels;
    frame_start(2'd2);
    for (int y = 0; y < 6; y++) send_line(y, 8, 2);
    idle(8);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {8'd30, 8'd20, 8'd10}) begin
        bad++;
        $display("FAIL chan_%0d got=%h want=1e140a", i, obs_q[i]);
      end
    end
    end_frame("chan", 24);
  endtask

  task automatic test_modes;
    frame_start(2'd1);
    for (int y = 0; y < 6; y++) begin
      if (y == 3) mode_drv = 2'd0;
      send_line(y, 8, 3);
    end
    end_frame("mode_hold", 24);
    frame_start(2'd0);
    for (int y = 0; y < 6; y++) send_line(y, 8, 3);
    end_frame("bypass", 24);
    frame_start(2'd3);
    for (int y = 0; y < 5; y++) send_line(y, 9, 3);
    end_frame("horiz", 21);
    frame_start(2'd2);
    for (int y = 0; y < 4; y++) send_line(y, 6, 3);
    end_frame("cross", 8);
  endtask

  task automatic test_overflow;
    frame_start(2'd1);
    for (int y = 0; y < 4; y++) send_line(y, 18, 3);
    end_frame("ovf", 28);
    total++;
    if (ovf_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", ovf_o);
    end
    frame_start(2'd1);
    for (int y = 0; y < 3; y++) send_line(y, 16, 3);
    end_frame("after_ovf", 14);
  endtask

  task automatic test_reset_midline;
    logic [PW-1:0] d;
    frame_start(2'd1);
    send_line(0, 8, 3);
    send_line(1, 8, 3);
    for (int x = 0; x < 4; x++) begin
      d = make_pix(3, x, 2);
      img[2][x] = d;
      if (x >= 2) begin
        e.data = kern(2, x, frame_mode);
        e.cyc  = cyc + 5;
        sb_q.push_back(e);
      end
      drive(1'b0, 1'b1, d, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    ovf_exp = 1'b0;
    total++;
    if (do_o !== '0 || de_o !== 1'b0 || hs_o !== 1'b0 || vs_o !== 1'b0 || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL midline_reset got do=%h de=%b hs=%b vs=%b ovf=%b want all 0",
               do_o, de_o, hs_o, vs_o, ovf_o);
    end
    pulses = 0;
    for (int y = 0; y < 4; y++) send_line(y, 8, 3);
    end_frame("post_reset", 12);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_flat();
    test_impulse();
    test_channels();
    test_modes();
    test_overflow();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
